// File: rtl/host_bus_master_pkg.sv
// Shared types and constants for the squat host-bus initiator: bus encodings,
// FSM state codes and the default data width derived from the port count.
package host_bus_master_pkg;

    localparam int unsigned PORT_NUM = 4;
    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned DATA_W   = 12 + PORT_NUM;

    // Bus cycle encoding as seen on {Sel, Rd_DS, Wr_RW}
    typedef struct packed {
        logic sel;
        logic rd_ds;
        logic wr_rw;
    } bus_enc_t;

    localparam bus_enc_t BUS_IDLE  = 3'b111;
    localparam bus_enc_t BUS_WRITE = 3'b010;
    localparam bus_enc_t BUS_READ  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

endpackage

// File: rtl/host_bus_master_timer.sv
// Strobe-length / timeout counter. The expiry comparator only exists when
// HOST_TIMEOUT_EN is defined; otherwise expired is tied low.
module host_bus_timer #(
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic min_done,
    output logic expired
);

    localparam int unsigned CNT_MAX = (TIMEOUT > STROBE_CYC) ? TIMEOUT : STROBE_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] cnt;

    // Loaded with 1 so the first strobe cycle reads as count 1; saturates so a
    // stalled slave never wraps the count back below the minimum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= CNT_W'(1);
        end else if (en && (cnt != CNT_W'(CNT_MAX))) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign min_done = (cnt >= CNT_W'(STROBE_CYC));

`ifdef HOST_TIMEOUT_EN
    assign expired = (cnt >= CNT_W'(TIMEOUT));
`else
    assign expired = 1'b0;
`endif

endmodule

// File: rtl/host_bus_master.sv
// Single-word host-bus initiator for the squat lookup-table port: command in,
// one bus cycle out, one-cycle response strobe back. Optional HOST_TIMEOUT_EN.
module host_bus_master
    import host_bus_master_pkg::*;
#(
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned DW         = DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DW-1:0]     cmd_wdata,
    output logic              rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic              BusMode,
    output logic [ADDR_W-1:0] Addr,
    output logic              Sel,
    output logic [DW-1:0]     DataIn,
    output logic              Rd_DS,
    output logic              Wr_RW,
    input  logic [DW-1:0]     DataOut,
    input  logic              Rdy_Dtack
);

    state_t            state;
    state_t            next_state;
    bus_enc_t          bus;
    bus_enc_t          bus_d;
    logic              we_q;
    logic              we_d;
    logic              cmd_ready_d;
    logic              rsp_valid_d;
    logic [DW-1:0]     rsp_rdata_d;
    logic              rsp_err_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DW-1:0]     din_d;
    logic              min_done;
    logic              expired;
    logic              accept;
    logic              ack;
    logic              abort;
    logic              done;

    host_bus_timer #(
        .STROBE_CYC (STROBE_CYC),
        .TIMEOUT    (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state == ST_SETUP),
        .en       (state == ST_STROBE),
        .min_done (min_done),
        .expired  (expired)
    );

    assign accept = (state == ST_IDLE) && cmd_valid && cmd_ready;
    assign ack    = (state == ST_STROBE) && min_done && !Rdy_Dtack;
    // An acknowledge on the expiry cycle takes priority over the abort
    assign abort  = (state == ST_STROBE) && expired && !ack;
    assign done   = ack || abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (accept) next_state = ST_SETUP;
            ST_SETUP:   next_state = ST_STROBE;
            ST_STROBE:  if (done) next_state = ST_RECOVER;
            ST_RECOVER: next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, keyed on the state being entered
    always_comb begin
        cmd_ready_d = (next_state == ST_IDLE);
        rsp_valid_d = done;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        addr_d      = Addr;
        din_d       = DataIn;
        we_d        = we_q;
        bus_d       = BUS_IDLE;
        if (accept) begin
            addr_d = cmd_addr;
            din_d  = cmd_wdata;
            we_d   = cmd_we;
        end
        if (done) begin
            rsp_err_d   = abort;
            rsp_rdata_d = (ack && !we_q) ? DataOut : '0;
        end
        if (next_state == ST_STROBE) begin
            bus_d = we_q ? BUS_WRITE : BUS_READ;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            Addr      <= '0;
            DataIn    <= '0;
            we_q      <= 1'b0;
            bus       <= BUS_IDLE;
            BusMode   <= 1'b1;
        end else begin
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            Addr      <= addr_d;
            DataIn    <= din_d;
            we_q      <= we_d;
            bus       <= bus_d;
            BusMode   <= 1'b1;
        end
    end

    assign Sel   = bus.sel;
    assign Rd_DS = bus.rd_ds;
    assign Wr_RW = bus.wr_rw;

endmodule

// File: tb/tb_host_bus_master.sv
// Randomised self-checking bench for host_bus_master with a lookup-table slave
// and a per-command timeline model; timeout cases need HOST_TIMEOUT_EN.
module tb_host_bus_master;
    import host_bus_master_pkg::*;

    localparam int unsigned S   = 2;
    localparam int unsigned TMO = 8;
    localparam int unsigned DW  = DATA_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [11:0]   cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          BusMode;
    logic [11:0]   Addr;
    logic          Sel;
    logic [DW-1:0] DataIn;
    logic          Rd_DS;
    logic          Wr_RW;
    logic [DW-1:0] DataOut;
    logic          Rdy_Dtack;
    logic [2:0]    bus;

    assign bus = {Sel, Rd_DS, Wr_RW};

    always #5 clk = ~clk;

    host_bus_master #(.STROBE_CYC(S), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .BusMode(BusMode), .Addr(Addr), .Sel(Sel), .DataIn(DataIn),
        .Rd_DS(Rd_DS), .Wr_RW(Wr_RW), .DataOut(DataOut), .Rdy_Dtack(Rdy_Dtack)
    );

    typedef struct {
        logic          ready;
        logic [2:0]    bus;
        logic [11:0]   addr;
        logic [DW-1:0] din;
        logic          rv;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          expq[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            run_len = 0;
    int            last_strobe = 0;
    int            idle_run = 0;
    int            min_gap = 1000;
    bit            seen_strobe = 0;
    int            last_rsp_cyc = 0;
    logic [DW-1:0] last_rdata = '0;
    logic          last_err = 1'b0;
    int            acc_cyc = 0;
    logic [11:0]   m_addr = '0;
    logic [DW-1:0] m_din = '0;
    logic [DW-1:0] ref_mem [4096];
    logic [DW-1:0] slave_mem [4096];
    int            ack_k = 1;
    int            scnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Lookup-table slave: acknowledges from the ack_k-th strobe cycle onward
    always @(negedge clk) begin
        if ((bus == 3'b010) || (bus == 3'b001)) begin
            scnt = scnt + 1;
            Rdy_Dtack = (scnt >= ack_k) ? 1'b0 : 1'b1;
            if (!Rdy_Dtack && (bus == 3'b010)) slave_mem[Addr] = DataIn;
            DataOut = slave_mem[Addr];
        end else begin
            scnt = 0;
            Rdy_Dtack = 1'($urandom);
            DataOut = DW'($urandom);
        end
    end

    // Cycle monitor and the single compare process against the model queue
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus != 3'b111) begin
                if (run_len == 0 && seen_strobe && idle_run < min_gap) min_gap = idle_run;
                run_len++;
                idle_run = 0;
                seen_strobe = 1;
            end else begin
                if (run_len > 0) last_strobe = run_len;
                run_len = 0;
                idle_run++;
            end
            if (rsp_valid) begin
                last_rsp_cyc = cyc;
                last_rdata = rsp_rdata;
                last_err = rsp_err;
            end
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("cmd_ready", 32'(cmd_ready), 32'(e.ready));
                chk("bus", 32'(bus), 32'(e.bus));
                chk("Addr", 32'(Addr), 32'(e.addr));
                chk("DataIn", 32'(DataIn), 32'(e.din));
                chk("rsp_valid", 32'(rsp_valid), 32'(e.rv));
                chk("BusMode", 32'(BusMode), 32'd1);
                if (e.rv) begin
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    end

    function automatic void push(logic ready, logic [2:0] b, logic rv, logic [DW-1:0] rd, logic err);
        exp_t e;
        e.ready = ready; e.bus = b; e.addr = m_addr; e.din = m_din;
        e.rv = rv; e.rdata = rd; e.err = err;
        expq.push_back(e);
    endfunction

    // Advance one cycle; while busy, either hold the command or throw noise at it
    task automatic busy_step(input bit hold);
        @(negedge clk);
        if (!hold) begin
            cmd_valid = 1'($urandom);
            cmd_we    = 1'($urandom);
            cmd_addr  = 12'($urandom);
            cmd_wdata = DW'($urandom);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cmd_valid = 1'b0;
            push(1'b1, 3'b111, 1'b0, '0, 1'b0);
            @(negedge clk);
        end
    endtask

    // Issue one command in a ready cycle; the strobe lasts max(S, k) cycles,
    // or TMO cycles with an error when the slave would answer after TMO.
    task automatic do_cmd(input logic we, input logic [11:0] addr, input logic [DW-1:0] wd,
                          input int k, input bit hold);
        int            len;
        logic          err;
        logic [DW-1:0] rd;
        ack_k = k;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd;
        acc_cyc = cyc;
        len = (k > int'(S)) ? k : int'(S);
        err = 1'b0;
`ifdef HOST_TIMEOUT_EN
        if (k > int'(TMO)) begin
            len = int'(TMO);
            err = 1'b1;
        end
`endif
        rd = (we || err) ? '0 : ref_mem[addr];
        if (we && !err) ref_mem[addr] = wd;
        m_addr = addr;
        m_din = wd;
        push(1'b0, 3'b111, 1'b0, '0, 1'b0);
        busy_step(hold);
        for (int i = 0; i < len; i++) begin
            push(1'b0, we ? 3'b010 : 3'b001, 1'b0, '0, 1'b0);
            busy_step(hold);
        end
        push(1'b0, 3'b111, 1'b1, rd, err);
        busy_step(hold);
        push(1'b1, 3'b111, 1'b0, '0, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int acc[3];
        for (int i = 0; i < 4096; i++) begin
            ref_mem[i] = '0;
            slave_mem[i] = '0;
        end
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        repeat (3) @(negedge clk);

        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_Addr", 32'(Addr), 32'd0);
        chk("rst_DataIn", 32'(DataIn), 32'd0);
        chk("rst_bus", 32'(bus), 32'h7);
        chk("rst_BusMode", 32'(BusMode), 32'd1);

        rst_n = 1'b1;
        idle(2);

        // Directed write with immediate acknowledge
        do_cmd(1'b1, 12'h05A, DW'(16'h1234), 1, 1'b0);
        chk("wr_latency", 32'(last_rsp_cyc - acc_cyc), 32'd4);
        chk("wr_strobe_len", 32'(last_strobe), 32'd2);
        chk("wr_rdata", 32'(last_rdata), 32'd0);
        chk("wr_err", 32'(last_err), 32'd0);

        // Read-back
        idle(1);
        do_cmd(1'b0, 12'h05A, DW'(16'h0F0F), 1, 1'b0);
        chk("rd_rdata", 32'(last_rdata), 32'h1234);
        chk("rd_strobe_len", 32'(last_strobe), 32'd2);

        // Slow acknowledge: six strobe cycles with Rdy_Dtack high
        do_cmd(1'b1, 12'h0B0, DW'(16'h0777), 7, 1'b0);
        chk("slow_strobe_len", 32'(last_strobe), 32'd7);
        chk("slow_latency", 32'(last_rsp_cyc - acc_cyc), 32'd9);

`ifdef HOST_TIMEOUT_EN
        do_cmd(1'b1, 12'h0A0, DW'(16'hBEEF), int'(TMO) + 4, 1'b0);
        chk("tmo_strobe_len", 32'(last_strobe), 32'd8);
        chk("tmo_err", 32'(last_err), 32'd1);
        chk("tmo_rdata", 32'(last_rdata), 32'd0);
        do_cmd(1'b1, 12'h0A1, DW'(16'h4321), int'(TMO), 1'b0);
        chk("tmo_ack_wins_err", 32'(last_err), 32'd0);
        do_cmd(1'b0, 12'h0A1, '0, 1, 1'b0);
        chk("tmo_ack_wins_rdata", 32'(last_rdata), 32'h4321);
`endif

        // Reset while a read is strobing; the command is dropped
        ack_k = 100;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 12'h05A; cmd_wdata = '0;
        m_addr = 12'h05A; m_din = '0;
        push(1'b0, 3'b111, 1'b0, '0, 1'b0);
        busy_step(1'b0);
        push(1'b0, 3'b001, 1'b0, '0, 1'b0);
        busy_step(1'b0);
        push(1'b0, 3'b001, 1'b0, '0, 1'b0);
        busy_step(1'b0);
        rst_n = 1'b0;
        m_addr = '0; m_din = '0;
        push(1'b0, 3'b111, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("rst_mid_Addr", 32'(Addr), 32'd0);
        rst_n = 1'b1;
        cmd_valid = 1'b0;
        push(1'b1, 3'b111, 1'b0, '0, 1'b0);
        @(negedge clk);
        do_cmd(1'b0, 12'h05A, '0, 1, 1'b0);
        chk("post_rst_rdata", 32'(last_rdata), 32'h1234);

        // Back-to-back writes with cmd_valid held high
        min_gap = 1000;
        for (int i = 0; i < 3; i++) begin
            acc[i] = cyc;
            do_cmd(1'b1, 12'(12'h0C0 + i), DW'(16'h0100 + i), 1, 1'b1);
        end
        chk("b2b_period_1", 32'(acc[1] - acc[0]), 32'd5);
        chk("b2b_period_2", 32'(acc[2] - acc[1]), 32'd5);
        chk("b2b_min_gap_ge2", 32'(min_gap >= 2), 32'd1);

        // Randomised traffic over a small address window
        for (int n = 0; n < 60; n++) begin
            logic          we;
            logic [11:0]   a;
            logic [DW-1:0] d;
            int            k;
            bit            hold;
            we = 1'($urandom);
            a = 12'($urandom_range(0, 15));
            d = DW'($urandom);
`ifdef HOST_TIMEOUT_EN
            k = $urandom_range(1, int'(TMO) + 3);
`else
            k = $urandom_range(1, 6);
`endif
            hold = 1'($urandom);
            if (!hold) idle($urandom_range(0, 2));
            do_cmd(we, a, d, k, hold);
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
